// File: rtl/calc1_core.sv
// Four-port 32-bit calculator: add, subtract, shift left/right logical.
// Each port takes cmd+op1, then op2, and answers one cycle later for one cycle.
module calc1_core (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
);

  typedef enum logic {IDLE, WAIT_OP2} state_t;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // MSB-first port vectors map onto conventional [n:0] arrays value-for-value.
  logic [3:0]  cmd_a  [4];
  logic [31:0] din_a  [4];
  logic [1:0]  resp_a [4];
  logic [31:0] dout_a [4];

  assign cmd_a[0] = req1_cmd_in;
  assign cmd_a[1] = req2_cmd_in;
  assign cmd_a[2] = req3_cmd_in;
  assign cmd_a[3] = req4_cmd_in;
  assign din_a[0] = req1_data_in;
  assign din_a[1] = req2_data_in;
  assign din_a[2] = req3_data_in;
  assign din_a[3] = req4_data_in;

  assign out_resp1 = resp_a[0];
  assign out_data1 = dout_a[0];
  assign out_resp2 = resp_a[1];
  assign out_data2 = dout_a[1];
  assign out_resp3 = resp_a[2];
  assign out_data3 = dout_a[2];
  assign out_resp4 = resp_a[3];
  assign out_data4 = dout_a[3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      state_t      state_reg, state_next;
      logic [3:0]  cmd_reg, cmd_next;
      logic [31:0] op1_reg, op1_next;
      logic [1:0]  resp_reg, resp_next;
      logic [31:0] dout_reg, dout_next;
      logic [32:0] sum;

      always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          cmd_reg   <= CMD_NOP;
          op1_reg   <= '0;
          resp_reg  <= RESP_NONE;
          dout_reg  <= '0;
        end else begin
          state_reg <= state_next;
          cmd_reg   <= cmd_next;
          op1_reg   <= op1_next;
          resp_reg  <= resp_next;
          dout_reg  <= dout_next;
        end
      end

      // Response defaults to none so every result is exactly one cycle wide.
      always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        op1_next   = op1_reg;
        resp_next  = RESP_NONE;
        dout_next  = '0;
        sum        = {1'b0, op1_reg} + {1'b0, din_a[gi]};
        if (state_reg == IDLE) begin
          if (cmd_a[gi] != CMD_NOP) begin
            state_next = WAIT_OP2;
            cmd_next   = cmd_a[gi];
            op1_next   = din_a[gi];
          end
        end else begin
          state_next = IDLE;
          case (cmd_reg)
            CMD_ADD: begin
              if (sum[32]) begin
                resp_next = RESP_ERR;
              end else begin
                resp_next = RESP_OK;
                dout_next = sum[31:0];
              end
            end
            CMD_SUB: begin
              if (din_a[gi] > op1_reg) begin
                resp_next = RESP_ERR;
              end else begin
                resp_next = RESP_OK;
                dout_next = op1_reg - din_a[gi];
              end
            end
            CMD_SHL: begin
              resp_next = RESP_OK;
              dout_next = op1_reg << din_a[gi][4:0];
            end
            CMD_SHR: begin
              resp_next = RESP_OK;
              dout_next = op1_reg >> din_a[gi][4:0];
            end
            default: resp_next = RESP_ERR;
          endcase
        end
      end

      assign resp_a[gi] = resp_reg;
      assign dout_a[gi] = dout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_calc1_core.sv
// Self-checking bench for calc1_core: directed cases, walking-one sweep,
// concurrent ports, reset mid-operation and randomized traffic vs. a model.
module tb_calc1_core;

  logic        c_clk;
  logic        reset;
  logic [0:3]  cmd_tb  [4];
  logic [0:31] din_tb  [4];
  logic [0:1]  resp_tb [4];
  logic [0:31] data_tb [4];

  int checks   = 0;
  int pass_cnt = 0;

  calc1_core dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (cmd_tb[0]),
    .req1_data_in(din_tb[0]),
    .req2_cmd_in (cmd_tb[1]),
    .req2_data_in(din_tb[1]),
    .req3_cmd_in (cmd_tb[2]),
    .req3_data_in(din_tb[2]),
    .req4_cmd_in (cmd_tb[3]),
    .req4_data_in(din_tb[3]),
    .out_resp1   (resp_tb[0]),
    .out_data1   (data_tb[0]),
    .out_resp2   (resp_tb[1]),
    .out_data2   (data_tb[1]),
    .out_resp3   (resp_tb[2]),
    .out_data3   (data_tb[2]),
    .out_resp4   (resp_tb[3]),
    .out_data4   (data_tb[3])
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // Reference: {resp, data} from plain unsigned arithmetic.
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned s;
    longint unsigned pw;
    pw = 1;
    for (int k = 0; k < int'(b % 32); k++) pw = pw * 2;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s >= 64'h1_0000_0000) return {2'd2, 32'd0};
        return {2'd1, s[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        s = longint'(a) - longint'(b);
        return {2'd1, s[31:0]};
      end
      4'd5: begin
        s = (longint'(a) * pw) % 64'h1_0000_0000;
        return {2'd1, s[31:0]};
      end
      4'd6: begin
        s = longint'(a) / pw;
        return {2'd1, s[31:0]};
      end
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic chk(input string tag, input int p, input logic [1:0] er, input logic [31:0] ed);
    checks++;
    assert (resp_tb[p] === er && data_tb[p] === ed) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s port%0d: got resp=%0d data=%h, want resp=%0d data=%h",
             tag, p + 1, resp_tb[p], data_tb[p], er, ed);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is checked,
  // so consecutive calls issue back-to-back requests.
  task automatic run_op(input string tag, input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b);
    logic [33:0] e;
    cmd_tb[p] = c;
    din_tb[p] = a;
    @(negedge c_clk);
    chk({tag, "_gap"}, p, 2'd0, 32'd0);
    cmd_tb[p] = 4'($urandom);
    din_tb[p] = b;
    @(negedge c_clk);
    e = model(c, a, b);
    chk(tag, p, e[33:32], e[31:0]);
    cmd_tb[p] = 4'd0;
    din_tb[p] = $urandom;
  endtask

  task automatic run_all(input string tag, input logic [3:0] c[4],
                         input logic [31:0] a[4], input logic [31:0] b[4]);
    logic [33:0] e;
    for (int p = 0; p < 4; p++) begin
      cmd_tb[p] = c[p];
      din_tb[p] = a[p];
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      cmd_tb[p] = 4'($urandom);
      din_tb[p] = b[p];
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      e = model(c[p], a[p], b[p]);
      chk(tag, p, e[33:32], e[31:0]);
      cmd_tb[p] = 4'd0;
    end
  endtask

  logic [3:0]  cv [4];
  logic [31:0] av [4];
  logic [31:0] bv [4];

  initial begin
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cmd_tb[p] = 4'd0;
      din_tb[p] = 32'd0;
    end
    #2 reset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) chk("reset_hold", p, 2'd0, 32'd0);
    repeat (2) @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) chk("reset_rel", p, 2'd0, 32'd0);

    // Directed cases from the test plan.
    run_op("add_a", 0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF);
    run_op("add_b", 0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    run_op("add_ovf", 0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("add_zero", 0, 4'd1, 32'h0, 32'h0);
    run_op("sub_unf", 0, 4'd2, 32'h1, 32'hF);
    run_op("sub_ok", 0, 4'd2, 32'hF, 32'h1);
    run_op("sub_eq", 0, 4'd2, 32'h1234_5678, 32'h1234_5678);
    run_op("inv3", 0, 4'd3, $urandom, $urandom);
    run_op("inv4", 0, 4'd4, $urandom, $urandom);
    run_op("inv15", 0, 4'd15, $urandom, $urandom);
    run_op("shl_upper", 0, 4'd5, 32'h0000_0003, 32'hFFFF_FFE4);
    run_op("shr_31", 0, 4'd6, 32'hFFFF_FFFF, 32'd31);
    @(negedge c_clk);
    chk("idle_after", 0, 2'd0, 32'd0);

    for (int i = 0; i <= 30; i++) begin
      run_op("walk_add", 0, 4'd1, 32'd1 << i, 32'd0);
      run_op("walk_shl", 0, 4'd5, 32'd1 << i, 32'd1);
      run_op("walk_shr", 0, 4'd6, 32'h8000_0000, i);
    end

    cv = '{4'd1, 4'd2, 4'd5, 4'd6};
    av = '{32'h7000_0000, 32'h0000_1000, 32'h0000_00FF, 32'hF000_0000};
    bv = '{32'h0FFF_FFFF, 32'h0000_0001, 32'd8, 32'd4};
    run_all("concurrent", cv, av, bv);

    // Reset during WAIT_OP2 on port 1 while port 2 shows a response.
    @(negedge c_clk);
    cmd_tb[1] = 4'd1;
    din_tb[1] = 32'd3;
    @(negedge c_clk);
    cmd_tb[1] = 4'd0;
    din_tb[1] = 32'd4;
    cmd_tb[0] = 4'd1;
    din_tb[0] = 32'd5;
    @(negedge c_clk);
    chk("rst_pre", 1, 2'd1, 32'd7);
    cmd_tb[0] = 4'd0;
    din_tb[0] = 32'd6;
    #2 reset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) chk("rst_async", p, 2'd0, 32'd0);
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    chk("rst_nolate", 0, 2'd0, 32'd0);
    @(negedge c_clk);
    chk("rst_nolate2", 0, 2'd0, 32'd0);

    for (int n = 0; n < 150; n++) begin
      int p;
      logic [31:0] a;
      logic [31:0] b;
      p = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op("rand", p, 4'($urandom_range(1, 15)), a, b);
    end

    for (int n = 0; n < 30; n++) begin
      for (int p = 0; p < 4; p++) begin
        cv[p] = 4'($urandom_range(1, 15));
        av[p] = $urandom;
        bv[p] = $urandom;
      end
      run_all("rand_all", cv, av, bv);
    end

    @(negedge c_clk);
    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule
